// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store encodings and the responder FSM state type.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Stores have no unsigned variants, so any funct3[2]=1 store is rejected too.
  function automatic logic funct3_illegal(input logic [2:0] funct3, input logic write);
    logic bad;
    case (funct3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = 1'b0;
    endcase
    return bad || (write && funct3[2]);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane selection plus extension for loads.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  // Store data is replicated across lanes; byte_en picks which lanes land.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    load_data   = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        load_data   = word;
      end
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for an RV32I core: one request at a time, a fixed
// number of wait states, byte-lane stores and sign/zero-extended loads.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t state, state_next;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             op_write;
  logic [31:0]      op_addr;
  logic [2:0]       op_funct3;
  logic [31:0]      op_wdata;
  logic             misaligned;
  logic             out_of_range;
  logic             op_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes;
  logic [31:0]      load_data;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state != RESP) && (state_next == RESP);

  // With zero wait states RESP is entered on the accept edge, before the
  // registered copy exists, so the live request is used while in IDLE.
  assign op_write  = (state == IDLE) ? req_write  : write_q;
  assign op_addr   = (state == IDLE) ? req_addr   : addr_q;
  assign op_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
  assign op_wdata  = (state == IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    misaligned = 1'b0;
    case (op_funct3[1:0])
      2'b01:   misaligned = op_addr[0];
      2'b10:   misaligned = |op_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = {2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign op_err       = misaligned || out_of_range || funct3_illegal(op_funct3, op_write);
  assign idx          = op_addr[IDX_W+1:2];

  load_store_align u_align (
    .funct3      (op_funct3),
    .addr_lo     (op_addr[1:0]),
    .wdata       (op_wdata),
    .word        (mem[idx]),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt <= 4'(WAIT_STATES);
        write_q  <= req_write;
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (op_err || op_write) ? 32'h0 : load_data;
        err_q   <= op_err;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (wait_cnt == 4'd1) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: req_ready = reset;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Storage has no reset; a store lands only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_STATES = 1;
  localparam int EXP_LAT     = 1 + WAIT_STATES;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [4*DEPTH_WORDS];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference model: byte-addressed memory, sizes and extension from funct3.
  function automatic void model_txn(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                    input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int     size;
    bit     uns;
    bit     illegal;
    longint v;
    size = 0; uns = 0; illegal = 0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; end
      3'd5: begin size = 2; uns = 1; end
      default: illegal = 1;
    endcase
    if (wr && f3 >= 3'd4) illegal = 1;
    er = illegal || ((addr % size) != 0) || ((addr / 4) >= DEPTH_WORDS);
    rd = 32'h0;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < size; i++) model_mem[int'(addr) + i] = 8'(wd >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(model_mem[int'(addr) + i]) << (8 * i));
      if (!uns && size < 4 && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
      rd = v[31:0];
    end
  endfunction

  // Full handshake: request until accepted, then wait for and retire the response.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                output int lat);
    int guard;
    rd = 32'h0; er = 1'b0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: actual=req_ready low required=accept within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout: actual=no rsp_valid required=rsp_valid within 40 cycles");
      return;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic random_txn(input logic wr, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;
    model_txn(wr, addr, f3, wd, exp_rd, exp_er);
    apply_stimulus(wr, addr, f3, wd, rd, er, lat);
    check_output($sformatf("rand_rdata wr=%0b a=%h f3=%0d", wr, addr, f3), rd, exp_rd);
    check_output($sformatf("rand_err wr=%0b a=%h f3=%0d", wr, addr, f3), 32'(er), 32'(exp_er));
    check_output("rand_latency", 32'(lat), 32'(EXP_LAT));
  endtask

  initial begin
    logic [31:0] rd, dummy_rd;
    logic        er, dummy_er;
    int          lat, guard;
    logic [31:0] a;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_output("reset_req_ready", 32'(req_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_output("reset_rsp_err", 32'(rsp_err), 32'h0);
    reset = 1'b1;
    #1;
    check_output("release_req_ready", 32'(req_ready), 32'h1);

    vecs.push_back('{1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0, "sw_10"});
    vecs.push_back('{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10"});
    vecs.push_back('{1'b1, 32'h11,  3'b000, 32'h00000080, 32'h00000000, 1'b0, "sb_11"});
    vecs.push_back('{1'b0, 32'h11,  3'b000, 32'h0,        32'hFFFFFF80, 1'b0, "lb_11"});
    vecs.push_back('{1'b0, 32'h11,  3'b100, 32'h0,        32'h00000080, 1'b0, "lbu_11"});
    vecs.push_back('{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEAD80EF, 1'b0, "lw_10_after_sb"});
    vecs.push_back('{1'b0, 32'h13,  3'b001, 32'h0,        32'h00000000, 1'b1, "lh_13_misaligned"});
    vecs.push_back('{1'b1, 32'h12,  3'b010, 32'hCAFEF00D, 32'h00000000, 1'b1, "sw_12_misaligned"});
    vecs.push_back('{1'b0, 32'h10,  3'b010, 32'h0,        32'hDEAD80EF, 1'b0, "lw_10_unchanged"});
    vecs.push_back('{1'b0, 32'h12,  3'b001, 32'h0,        32'hFFFFDEAD, 1'b0, "lh_12"});
    vecs.push_back('{1'b0, 32'h12,  3'b101, 32'h0,        32'h0000DEAD, 1'b0, "lhu_12"});
    vecs.push_back('{1'b0, 32'h400, 3'b010, 32'h0,        32'h00000000, 1'b1, "lw_400_range"});
    vecs.push_back('{1'b1, 32'h3FC, 3'b010, 32'h0BADF00D, 32'h00000000, 1'b0, "sw_3fc"});
    vecs.push_back('{1'b0, 32'h3FC, 3'b010, 32'h0,        32'h0BADF00D, 1'b0, "lw_3fc_top"});
    vecs.push_back('{1'b1, 32'h14,  3'b100, 32'h000000AA, 32'h00000000, 1'b1, "sbu_illegal"});
    vecs.push_back('{1'b0, 32'h10,  3'b011, 32'h0,        32'h00000000, 1'b1, "f3_011_illegal"});
    vecs.push_back('{1'b1, 32'h20,  3'b010, 32'hA5A55A5A, 32'h00000000, 1'b0, "sw_20"});

    foreach (vecs[i]) begin
      model_txn(vecs[i].wr, vecs[i].addr, vecs[i].f3, vecs[i].wd, dummy_rd, dummy_er);
      apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].f3, vecs[i].wd, rd, er, lat);
      check_output({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check_output({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check_output({vecs[i].name, "_latency"}, 32'(lat), 32'(EXP_LAT));
    end

    // Response held by backpressure while a competing store is presented.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_output("hold_first_valid", 32'(rsp_valid), 32'h1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("hold_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
      check_output($sformatf("hold_rsp_rdata_%0d", i), rsp_rdata, 32'hDEAD80EF);
      check_output($sformatf("hold_req_ready_%0d", i), 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_output("hold_release_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("hold_release_req_ready", 32'(req_ready), 32'h1);
    apply_stimulus(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    check_output("hold_ignored_store", rd, 32'hDEAD80EF);

    // Reset pulsed while a store waits: no response and no write.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("abort_in_wait", 32'(rsp_valid), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check_output("abort_req_ready", 32'(req_ready), 32'h0);
    check_output("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("abort_rsp_rdata", rsp_rdata, 32'h0);
    check_output("abort_rsp_err", 32'(rsp_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("abort_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
    end
    apply_stimulus(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    check_output("abort_old_value", rd, 32'hA5A55A5A);
    check_output("abort_old_err", 32'(er), 32'h0);

    // Randomized traffic over a small window, preceded by a full-word fill.
    for (int w = 0; w < 16; w++) random_txn(1'b1, 32'(w * 4), 3'b010, $urandom);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) a = (32'($urandom_range(DEPTH_WORDS, 4000)) << 2) | 32'($urandom_range(0, 3));
      else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      random_txn(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, giving the extra cycles between request accept and response (0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the core presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the responder can accept a request.
REQ-007 The block SHALL have port req_write, input, 1, where 1 means store and 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_funct3, input, 3, the RV32I access type: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW use 000/001/010.
REQ-010 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the core accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, the extended load data (0 for stores and errors).
REQ-014 The block SHALL have port rsp_err, output, 1, flagging a misaligned, out-of-range or illegal-funct3 access.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and addr/funct3/wdata/write are registered at that moment.
REQ-017 On accept, the FSM SHALL go to WAIT with a down-counter loaded with WAIT_STATES; if WAIT_STATES=0 it SHALL go directly to RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the cycle the counter reaches 1; rsp_valid therefore rises exactly 1+WAIT_STATES cycles after the accept edge.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready is 1, then the FSM returns to IDLE on that edge; no new request is accepted in the same cycle.
REQ-020 Alignment SHALL be checked as follows: halfword requires addr[0]=0, word requires addr[1:0]=00, and byte is always aligned.
REQ-021 Range SHALL be checked as follows: addr[31:2] >= DEPTH_WORDS is out of range; funct3 011, 110 or 111, or a store with funct3 1xx, is illegal.
REQ-022 Any error condition SHALL give rsp_err=1 and rsp_rdata=0, with no storage modified.
REQ-023 A legal store SHALL write only the addressed byte lanes (SB: 1 lane by addr[1:0]; SH: 2 lanes by addr[1]; SW: all 4), on the edge entering RESP.
REQ-024 A legal load SHALL select the lane(s) by address; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word through.
REQ-025 A load to the word written by the immediately preceding store SHALL return the new data.
REQ-026 req_valid asserted outside IDLE SHALL be ignored; the requester holds its request until accepted.

Reset
REQ-027 While reset=0: the FSM SHALL be in IDLE, the counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL rise in the first cycle after release.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction with no response; a store aborted before entering RESP SHALL NOT modify storage.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 The funct3 encodings and the FSM state type SHALL live in shared package riscv_mem_pkg.
REQ-031 Lane selection, byte-enable generation and load extension SHALL be a combinational sub-module named load_store_align.

Verification
REQ-032 Bench scenario, with WAIT_STATES=1: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Bench scenario: SB 0x80 to 0x11, then LB 0x11 -> rdata 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-034 Bench scenario: LH at 0x13, and SW at 0x12 -> rsp_err=1, rdata=0; LW 0x10 is unchanged.
REQ-035 Bench scenario, with DEPTH_WORDS=256: LW 0x400 -> err=1; LW 0x3FC -> err=0.
REQ-036 Bench scenario: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; return to IDLE on the edge where rsp_ready=1.
REQ-037 Bench scenario: SW 0x12345678 to 0x20, with reset pulsed low during WAIT -> no response, outputs 0; a subsequent LW 0x20 returns the old value.
